// File: rtl/core_pkg.sv
// core_pkg: shared RV32I widths and ALU function encodings.
package core_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR = 3'b101;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_ALT = 7'b0100000;
endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// fwd_select: per-operand forwarding mux, EX over MEM over stored value, x0 never forwarded.
module fwd_select
  import core_pkg::*;
#(
  parameter int W = XLEN,
  parameter int AW = REG_W
) (
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  stored,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_rd,
  input  logic [W-1:0]  ex_data,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [W-1:0]  mem_data,
  output logic [W-1:0]  result
);
  logic nz;
  always_comb begin
    nz = addr != '0;
    result = (nz && ex_valid && ex_rd == addr) ? ex_data :
             (nz && mem_valid && mem_rd == addr) ? mem_data : stored;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-ALU stage with a two-entry skid buffer and forwarding snoop on held operands.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int REG_W = core_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [REG_W-1:0] in_rs1_addr,
  input  logic [REG_W-1:0] in_rs2_addr,
  input  logic [REG_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic             in_reg_write,
  input  logic             fwd_ex_valid,
  input  logic [REG_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]  fwd_ex_data,
  input  logic             fwd_mem_valid,
  input  logic [REG_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]  fwd_mem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [REG_W-1:0] out_rd_addr,
  output logic             out_reg_write,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_A,
  output logic [XLEN-1:0]  out_B
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE = 2'd1;
  localparam logic [1:0] TWO = 2'd2;
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             rw;
  } entry_t;
  logic [1:0] state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  entry_t in_e, main_src, skid_src, main_f, skid_f;
  logic [XLEN-1:0] main_a, main_b, skid_a, skid_b;
  logic accept, hs, cap_main, cap_skid;
  // Capture shares the snoop mux of whichever entry the new instruction lands in.
  fwd_select #(.W(XLEN), .AW(REG_W)) u_main_a (.addr(main_src.rs1), .stored(main_src.a),
    .ex_valid(fwd_ex_valid), .ex_rd(fwd_ex_rd), .ex_data(fwd_ex_data),
    .mem_valid(fwd_mem_valid), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data), .result(main_a));
  fwd_select #(.W(XLEN), .AW(REG_W)) u_main_b (.addr(main_src.rs2), .stored(main_src.b),
    .ex_valid(fwd_ex_valid), .ex_rd(fwd_ex_rd), .ex_data(fwd_ex_data),
    .mem_valid(fwd_mem_valid), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data), .result(main_b));
  fwd_select #(.W(XLEN), .AW(REG_W)) u_skid_a (.addr(skid_src.rs1), .stored(skid_src.a),
    .ex_valid(fwd_ex_valid), .ex_rd(fwd_ex_rd), .ex_data(fwd_ex_data),
    .mem_valid(fwd_mem_valid), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data), .result(skid_a));
  fwd_select #(.W(XLEN), .AW(REG_W)) u_skid_b (.addr(skid_src.rs2), .stored(skid_src.b),
    .ex_valid(fwd_ex_valid), .ex_rd(fwd_ex_rd), .ex_data(fwd_ex_data),
    .mem_valid(fwd_mem_valid), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data), .result(skid_b));
  always_comb begin
    in_ready = state_q != TWO;
    out_valid = state_q != EMPTY;
    accept = in_valid && in_ready && !flush;
    hs = out_valid && out_ready;
    cap_main = accept && (state_q == EMPTY || hs);
    cap_skid = accept && state_q == ONE && !hs;
    in_e = '{pc: in_pc, rs1: in_rs1_addr, rs2: in_rs2_addr, rd: in_rd_addr, a: in_rs1_data,
             b: in_rs2_data, imm: in_imm, use_imm: in_use_imm, f3: in_funct3, f7: in_funct7,
             rw: in_reg_write};
    main_src = cap_main ? in_e : main_q;
    skid_src = cap_skid ? in_e : skid_q;
    main_f = main_src;
    main_f.a = main_a;
    main_f.b = main_b;
    skid_f = skid_src;
    skid_f.a = skid_a;
    skid_f.b = skid_b;
    main_d = (state_q == TWO && hs) ? skid_f : main_f;
    skid_d = skid_f;
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (accept ? ONE : EMPTY) :
              state_q == ONE ? ((accept && !hs) ? TWO : (!accept && hs) ? EMPTY : ONE) :
              (hs ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  // Only shifts keep funct7 on I-type; ADDI's immediate bits must not look like SUB.
  always_comb begin
    out_pc = main_q.pc;
    out_rd_addr = main_q.rd;
    out_reg_write = main_q.rw;
    out_funct3 = main_q.f3;
    out_funct7 = (main_q.use_imm && main_q.f3 != F3_SR) ? 7'b0 : main_q.f7;
    out_A = main_q.a;
    out_B = main_q.use_imm ? main_q.imm : main_q.b;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus backpressure, flush and reset sequences.
module tb_id_ex_stage;
  logic clk = 0, rst, flush, in_valid, in_ready, in_use_imm, in_reg_write;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm, fwd_ex_data, fwd_mem_data;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr, fwd_ex_rd, fwd_mem_rd, out_rd_addr;
  logic [2:0] in_funct3, out_funct3;
  logic [6:0] in_funct7, out_funct7;
  logic fwd_ex_valid, fwd_mem_valid, out_valid, out_ready, out_reg_write;
  logic [31:0] out_pc, out_A, out_B;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_reg_write(in_reg_write),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_A(out_A), .out_B(out_B));
  typedef struct {
    logic [4:0] rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic ui;
    logic [2:0] f3;
    logic [6:0] f7;
    logic exv;
    logic [4:0] exrd;
    logic [31:0] exd;
    logic memv;
    logic [4:0] memrd;
    logic [31:0] memd, ea, eb;
    logic [6:0] ef7;
  } vec_t;
  vec_t v[9];
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask
  task automatic idle();
    in_valid = 0; flush = 0; fwd_ex_valid = 0; fwd_mem_valid = 0;
    fwd_ex_rd = 0; fwd_mem_rd = 0; fwd_ex_data = 0; fwd_mem_data = 0;
  endtask
  task automatic drive(logic [31:0] pc, logic [4:0] r1, logic [4:0] r2, logic [31:0] d1,
                       logic [31:0] d2, logic [31:0] imm, logic ui, logic [2:0] f3, logic [6:0] f7);
    in_valid = 1; in_pc = pc; in_rs1_addr = r1; in_rs2_addr = r2; in_rd_addr = pc[6:2];
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = ui;
    in_funct3 = f3; in_funct7 = f7; in_reg_write = 1;
  endtask
  initial begin
    v[0] = '{5'd1, 5'd2, 32'd20, 32'd30, 32'd0, 1'b0, 3'b000, 7'h00, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd20, 32'd30, 7'h00};
    v[1] = '{5'd3, 5'd4, 32'd34, 32'd99, 32'd12, 1'b1, 3'b000, 7'h20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd34, 32'd12, 7'h00};
    v[2] = '{5'd3, 5'd0, 32'd7, 32'd0, 32'd5, 1'b1, 3'b101, 7'h20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd7, 32'd5, 7'h20};
    v[3] = '{5'd1, 5'd2, 32'd50, 32'd8, 32'd0, 1'b0, 3'b000, 7'h20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd50, 32'd8, 7'h20};
    v[4] = '{5'd5, 5'd6, 32'd1, 32'd9, 32'd0, 1'b0, 3'b000, 7'h00, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hAAAA, 32'd9, 7'h00};
    v[5] = '{5'd5, 5'd6, 32'd1, 32'd9, 32'd0, 1'b0, 3'b111, 7'h00, 1'b1, 5'd7, 32'h1111, 1'b1, 5'd6, 32'hCCCC, 32'd1, 32'hCCCC, 7'h00};
    v[6] = '{5'd0, 5'd2, 32'h55, 32'd3, 32'd0, 1'b0, 3'b100, 7'h00, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h55, 32'd3, 7'h00};
    v[7] = '{5'd8, 5'd9, 32'd11, 32'd22, 32'd0, 1'b0, 3'b010, 7'h00, 1'b1, 5'd10, 32'hE1, 1'b0, 5'd8, 32'hE2, 32'd11, 32'd22, 7'h00};
    v[8] = '{5'd8, 5'd9, 32'd11, 32'd22, 32'hFFFF_FFF0, 1'b1, 3'b110, 7'h20, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'd0, 32'd11, 32'hFFFF_FFF0, 7'h00};
    idle(); rst = 1; out_ready = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset in_ready", {31'd0, in_ready}, 1);
    chk("reset out_A", out_A, 0);
    chk("reset out_B", out_B, 0);
    chk("reset out_pc", out_pc, 0);
    chk("reset out_funct7", {25'd0, out_funct7}, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(32'h1000 + i * 4, v[i].rs1, v[i].rs2, v[i].d1, v[i].d2, v[i].imm, v[i].ui, v[i].f3, v[i].f7);
      fwd_ex_valid = v[i].exv; fwd_ex_rd = v[i].exrd; fwd_ex_data = v[i].exd;
      fwd_mem_valid = v[i].memv; fwd_mem_rd = v[i].memrd; fwd_mem_data = v[i].memd;
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 1);
      chk($sformatf("v%0d out_pc", i), out_pc, 32'h1000 + i * 4);
      chk($sformatf("v%0d out_A", i), out_A, v[i].ea);
      chk($sformatf("v%0d out_B", i), out_B, v[i].eb);
      chk($sformatf("v%0d out_funct7", i), {25'd0, out_funct7}, {25'd0, v[i].ef7});
      chk($sformatf("v%0d out_funct3", i), {29'd0, out_funct3}, {29'd0, v[i].f3});
    end
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("drain out_valid", {31'd0, out_valid}, 0);
    // Backpressure: two accepted, third refused, snoop on held main and skid.
    @(negedge clk); out_ready = 0; drive(32'h100, 5'd8, 5'd9, 32'h11, 32'd1, 0, 0, 3'b000, 7'h00);
    @(posedge clk); #1;
    chk("bp1 in_ready", {31'd0, in_ready}, 1);
    chk("bp1 out_pc", out_pc, 32'h100);
    @(negedge clk); drive(32'h104, 5'd10, 5'd11, 32'h22, 32'h33, 0, 0, 3'b111, 7'h00);
    @(posedge clk); #1;
    chk("bp2 in_ready", {31'd0, in_ready}, 0);
    chk("bp2 out_pc", out_pc, 32'h100);
    @(negedge clk); drive(32'h108, 5'd1, 5'd2, 32'h44, 32'h55, 0, 0, 3'b001, 7'h00);
    @(posedge clk); #1;
    chk("bp3 refused in_ready", {31'd0, in_ready}, 0);
    chk("bp3 out_pc", out_pc, 32'h100);
    @(negedge clk); idle();
    fwd_ex_valid = 1; fwd_ex_rd = 9; fwd_ex_data = 32'h1234;
    fwd_mem_valid = 1; fwd_mem_rd = 10; fwd_mem_data = 32'h5678;
    @(posedge clk); #1;
    chk("snoop out_B", out_B, 32'h1234);
    chk("snoop out_A", out_A, 32'h11);
    chk("snoop out_pc", out_pc, 32'h100);
    chk("snoop out_valid", {31'd0, out_valid}, 1);
    @(negedge clk); idle(); out_ready = 1;
    @(posedge clk); #1;
    chk("rel out_pc", out_pc, 32'h104);
    chk("rel skid A snooped", out_A, 32'h5678);
    chk("rel out_B", out_B, 32'h33);
    chk("rel in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    chk("rel drained", {31'd0, out_valid}, 0);
    // Flush from TWO with a concurrent in_valid.
    @(negedge clk); out_ready = 0; drive(32'h200, 5'd1, 5'd2, 1, 2, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk); drive(32'h204, 5'd1, 5'd2, 3, 4, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre-flush in_ready", {31'd0, in_ready}, 0);
    @(negedge clk); drive(32'h208, 5'd1, 5'd2, 5, 6, 0, 0, 0, 0); flush = 1;
    @(posedge clk); #1;
    chk("flush out_valid", {31'd0, out_valid}, 0);
    chk("flush in_ready", {31'd0, in_ready}, 1);
    @(negedge clk); idle(); out_ready = 1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post-flush out_valid", {31'd0, out_valid}, 0);
    end
    // Reset while ONE.
    @(negedge clk); out_ready = 0; drive(32'h300, 5'd3, 5'd4, 32'h9, 32'h8, 0, 0, 3'b110, 7'h20);
    @(posedge clk); #1;
    chk("pre-rst out_valid", {31'd0, out_valid}, 1);
    @(negedge clk); idle(); rst = 1;
    @(posedge clk); #1;
    chk("rst out_valid", {31'd0, out_valid}, 0);
    chk("rst in_ready", {31'd0, in_ready}, 1);
    chk("rst out_pc", out_pc, 0);
    chk("rst out_A", out_A, 0);
    chk("rst out_B", out_B, 0);
    chk("rst out_rd", {27'd0, out_rd_addr}, 0);
    chk("rst out_reg_write", {31'd0, out_reg_write}, 0);
    chk("rst out_funct3", {29'd0, out_funct3}, 0);
    chk("rst out_funct7", {25'd0, out_funct7}, 0);
    @(negedge clk); rst = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RV32I core. It sits directly upstream of the ALU: it captures decoded operands, resolves the immediate-versus-register B operand, and masks `funct7` for I-type operations. While an instruction waits here, the block keeps its operands current by snooping the EX and MEM forwarding buses. It presents `funct7`/`funct3`/`A`/`B` to the ALU through a two-entry skid buffer with a valid/ready handshake, so backpressure never creates a combinational path into decode.

## Interface
- `XLEN`, 32, datapath width
- `REG_W`, 5, register-address width

- `clk` in 1: clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: discard all held and incoming instructions
- `in_valid` in 1 / `in_ready` out 1: decode-side handshake
- `in_pc` in XLEN: instruction PC
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in REG_W: source and destination register addresses
- `in_rs1_data`, `in_rs2_data` in XLEN: register-file read data
- `in_imm` in XLEN: sign-extended immediate
- `in_use_imm` in 1: B operand is the immediate (I-type)
- `in_funct3` in 3, `in_funct7` in 7, `in_reg_write` in 1
- `fwd_ex_valid` in 1, `fwd_ex_rd` in REG_W, `fwd_ex_data` in XLEN: EX-stage result bus
- `fwd_mem_valid` in 1, `fwd_mem_rd` in REG_W, `fwd_mem_data` in XLEN: MEM-stage result bus
- `out_valid` out 1 / `out_ready` in 1: ALU-side handshake
- `out_pc` out XLEN, `out_rd_addr` out REG_W, `out_reg_write` out 1
- `out_funct3` out 3, `out_funct7` out 7, `out_A` out XLEN, `out_B` out XLEN: ALU operands

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds pc, rs1/rs2 addresses, rd, A, rs2 value, imm, use_imm, funct3, funct7, and reg_write.
- States: EMPTY (no entry valid), ONE (main valid), TWO (main and skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept with no output handshake → TWO; accept with handshake → ONE (main replaced); handshake with no accept → EMPTY.
  - TWO: handshake → ONE (skid moves to main); `in_ready`=0, so no accept occurs in TWO.
- Accept is `in_valid && in_ready`. The output handshake is `out_valid && out_ready`.
- `in_ready` = (state != TWO). It is a registered state decode only, with no dependence on `out_ready`.
- Forwarding at capture and on every held cycle: for each source register, if the address is nonzero, the EX bus takes priority over the MEM bus, and the MEM bus over the captured or held value. A bus matches when its `*_valid` is high and its rd equals the source address.
  - On capture, the forwarding result replaces the register-file data.
  - While held (main and skid), a matching bus overwrites the stored A or rs2 value on each clock.
  - x0 (address 0) is never forwarded.
- `out_B` = use_imm ? imm : rs2 value. Snooping never alters imm.
- `out_funct7` = (use_imm && funct3 != 3'b101) ? 7'b0 : funct7. This keeps ADDI from being treated as SUB and passes SRAI's `funct7[5]` through.
- `flush`: next state EMPTY and `out_valid`=0, regardless of handshakes. An `in_valid` asserted in the flush cycle is dropped.
- Priority: `rst` > `flush` > handshake/accept > snoop.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, all data outputs 0.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: one instruction per cycle while `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, every output except `out_A`/`out_B` holds stable. `out_A`/`out_B` may change only through forwarding snoop of the same logical register.
- After `out_ready` is deasserted, at most one further instruction is accepted (into skid). `in_ready` falls on the following edge.
- `rst` or `flush` asserted mid-handshake: the instruction is lost and `out_valid`=0 on the next cycle.

## Structure
- Shared package `core_pkg`: `XLEN`, `REG_W`, funct3 constants (`F3_ADD`=000, `F3_SLT`=010, `F3_SLTU`=011, `F3_XOR`=100, `F3_SR`=101, `F3_OR`=110, `F3_AND`=111), `F7_ALT`=7'b0100000.
- One sub-module, `fwd_select`: combinational per-operand priority mux (EX > MEM > stored, x0 excluded). It is instantiated four times: A and B for the main entry, A and B for the skid entry, with the capture path sharing the skid or main instance as appropriate.

## Test plan
- Basic issue: ADD (funct3=000, funct7=0), rs1 data 20, rs2 data 30, `out_ready`=1 → next cycle `out_valid`=1, A=20, B=30, funct7=0.
- ADDI masking: `in_funct7`=0100000, use_imm=1, imm=12, rs1=34 → `out_funct7`=0, B=12. SRAI (funct3=101, funct7=0100000) → `out_funct7`=0100000.
- Forwarding priority: rs1=x5, EX bus (x5, 0xAAAA) and MEM bus (x5, 0xBBBB) both valid → A=0xAAAA. With rs1=x0 and EX rd=x0 → A keeps register-file data.
- Backpressure and snoop: hold `out_ready`=0 while issuing 3 instructions → third is refused (`in_ready`=0 after the second). Then an EX result for the held main's rs2 (0x1234) arrives → `out_B`=0x1234 with other outputs unchanged. Release `out_ready` → both instructions emerge in order.
- Flush: state TWO plus `flush`=1 with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and nothing from that cycle issues later.
- Reset mid-stream: `rst` with state ONE → next cycle all outputs 0, `in_ready`=1.
